// File: rtl/riscv_core_wba_pkg.sv
// Shared types and constants for the integer register-file writeback arbiter.
package riscv_core_wba_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MDU = 2'd1,
        REQ_LSU = 2'd2
    } req_idx_e;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/riscv_core_rr_arbiter.sv
// Round-robin grant generator: searches from the pointer upward with wrap and
// moves the pointer just past the winner on every accepted request.
module riscv_core_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_grant_idx,
    output logic               o_accept
);

    if (NUM_REQ < 1 || NUM_REQ > 4) begin : g_bad_num_req
        $error("riscv_core_rr_arbiter: NUM_REQ must be in 1..4");
    end

    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [2:0] w_sum;
    logic [2:0] w_nxt_sum;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_accept    = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_sum       = '0;
        w_nxt_sum   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = {1'b0, r_ptr} + 3'(off);
            if (w_sum >= 3'(NUM_REQ)) begin
                w_sum = w_sum - 3'(NUM_REQ);
            end
            // Ready is forced low while reset is held, even before the first edge.
            if (!o_accept && i_rst_n && i_req[w_sum[1:0]]) begin
                o_accept              = 1'b1;
                o_grant[w_sum[1:0]]   = 1'b1;
                o_grant_idx           = w_sum[1:0];
                w_nxt_sum             = w_sum + 3'd1;
                w_ptr_nxt             = (w_nxt_sum >= 3'(NUM_REQ)) ? 2'd0 : w_nxt_sum[1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 2'd0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/riscv_core_wb_arbiter.sv
// Arbitrates ALU/MDU/LSU results onto the single RF write port (we3/a3/wd3),
// registering the winner one cycle after acceptance and suppressing x0 writes.
module riscv_core_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 64,
    parameter int AW      = 5
) (
    input  logic                    i_wba_clk,
    input  logic                    i_wba_rst_n,
    input  logic [NUM_REQ-1:0]      i_wba_req_valid,
    input  logic [NUM_REQ*AW-1:0]   i_wba_req_addr,
    input  logic [NUM_REQ*XLEN-1:0] i_wba_req_data,
    output logic [NUM_REQ-1:0]      o_wba_req_ready,
    output logic                    o_wba_rf_we3,
    output logic [AW-1:0]           o_wba_rf_a3,
    output logic [XLEN-1:0]         o_wba_rf_wd3,
    output logic [1:0]              o_wba_grant_id,
    output logic                    o_wba_busy
);

    import riscv_core_wba_pkg::*;

    logic [NUM_REQ-1:0] w_grant;
    logic [1:0]         w_grant_idx;
    logic               w_accept;
    logic [AW-1:0]      w_sel_addr;
    logic [XLEN-1:0]    w_sel_data;

    logic               r_we3;
    logic [AW-1:0]      r_a3;
    logic [XLEN-1:0]    r_wd3;
    logic [1:0]         r_grant_id;

    riscv_core_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_clk       (i_wba_clk),
        .i_rst_n     (i_wba_rst_n),
        .i_req       (i_wba_req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_accept    (w_accept)
    );

    assign w_sel_addr = i_wba_req_addr[w_grant_idx*AW +: AW];
    assign w_sel_data = i_wba_req_data[w_grant_idx*XLEN +: XLEN];

    assign o_wba_req_ready = w_grant;
    assign o_wba_busy      = i_wba_rst_n & (|(i_wba_req_valid & ~w_grant));

    // x0 writes are still accepted and recorded on a3/wd3/grant_id, only the enable is dropped.
    always_ff @(posedge i_wba_clk or negedge i_wba_rst_n) begin
        if (!i_wba_rst_n) begin
            r_we3      <= 1'b0;
            r_a3       <= '0;
            r_wd3      <= '0;
            r_grant_id <= REQ_ALU;
        end else begin
            r_we3 <= w_accept && (w_sel_addr != '0);
            if (w_accept) begin
                r_a3       <= w_sel_addr;
                r_wd3      <= w_sel_data;
                r_grant_id <= w_grant_idx;
            end
        end
    end

    assign o_wba_rf_we3   = r_we3;
    assign o_wba_rf_a3    = r_a3;
    assign o_wba_rf_wd3   = r_wd3;
    assign o_wba_grant_id = r_grant_id;

endmodule

// File: tb/tb_riscv_core_wb_arbiter.sv
// Randomised bench for the writeback arbiter, checked against a queue-free
// behavioural model of round-robin grant, one-cycle write latency and the RF.
module tb_riscv_core_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 64;
    localparam int A  = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [A-1:0]   req_addr [N];
    logic [XL-1:0]  req_data [N];
    logic [N*A-1:0] w_addr;
    logic [N*XL-1:0] w_data;

    logic [N-1:0]   o_ready;
    logic           o_we3;
    logic [A-1:0]   o_a3;
    logic [XL-1:0]  o_wd3;
    logic [1:0]     o_gid;
    logic           o_busy;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int k = 0; k < N; k++) begin
            w_addr[k*A +: A]   = req_addr[k];
            w_data[k*XL +: XL] = req_data[k];
        end
    end

    riscv_core_wb_arbiter #(
        .NUM_REQ (N),
        .XLEN    (XL),
        .AW      (A)
    ) dut (
        .i_wba_clk       (clk),
        .i_wba_rst_n     (rst_n),
        .i_wba_req_valid (req_valid),
        .i_wba_req_addr  (w_addr),
        .i_wba_req_data  (w_data),
        .o_wba_req_ready (o_ready),
        .o_wba_rf_we3    (o_we3),
        .o_wba_rf_a3     (o_a3),
        .o_wba_rf_wd3    (o_wd3),
        .o_wba_grant_id  (o_gid),
        .o_wba_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state.
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [63:0] m_wd3;
    logic [1:0]  m_gid;
    int          wait_cnt [N];
    logic [63:0] model_rf [32];
    logic [63:0] dut_rf   [32];

    // RF commits on the falling edge whatever the DUT drives.
    always @(negedge clk) begin
        if (rst_n && o_we3) dut_rf[o_a3] = o_wd3;
    end

    // Requesters must hold valid/addr/data stable until ready.
    logic [N-1:0]  p_hold;
    logic [A-1:0]  p_addr [N];
    logic [XL-1:0] p_data [N];
    initial p_hold = '0;
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst_n && p_hold[k]) begin
                assert (req_valid[k] && req_addr[k] == p_addr[k] && req_data[k] == p_data[k])
                    else $error("protocol violation on requester %0d", k);
            end
            p_hold[k] <= rst_n && req_valid[k] && !o_ready[k];
            p_addr[k] <= req_addr[k];
            p_data[k] <= req_data[k];
        end
    end

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g = '0;
        for (int off = 0; off < N; off++) begin
            int k = (m_ptr + off) % N;
            if (req_valid[k]) begin
                g[k] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_ptr     = 0;
        m_we      = 1'b0;
        m_a3      = '0;
        m_wd3     = '0;
        m_gid     = '0;
        req_valid = '0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    endtask

    task automatic present(input int k, input logic [4:0] a, input logic [63:0] d);
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_data[k]  = d;
    endtask

    // One clock: entered at posedge+1, checks at the falling edge, leaves at posedge+1.
    task automatic cycle();
        logic [N-1:0] g;
        @(negedge clk);
        g = model_grant();
        check("ready", 64'(o_ready), 64'(g));
        check("busy",  64'(o_busy),  64'(|(req_valid & ~g)));
        check("we3",   64'(o_we3),   64'(m_we));
        check("a3",    64'(o_a3),    64'(m_a3));
        check("wd3",   o_wd3,        m_wd3);
        check("gid",   64'(o_gid),   64'(m_gid));
        @(posedge clk);
        #1;
        m_we = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (g[k]) begin
                m_we  = (req_addr[k] != 5'd0);
                m_a3  = req_addr[k];
                m_wd3 = req_data[k];
                m_gid = 2'(k);
                m_ptr = (k + 1) % N;
                if (req_addr[k] != 5'd0) model_rf[req_addr[k]] = req_data[k];
                check("fair_wait", 64'(wait_cnt[k] < N), 64'd1);
                wait_cnt[k]  = 0;
                req_valid[k] = 1'b0;
            end else if (req_valid[k]) begin
                wait_cnt[k]++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && req_valid != '0; i++) cycle();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            req_addr[k] = '0;
            req_data[k] = '0;
        end
        for (int r = 0; r < 32; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end
        model_reset();
        req_valid = 3'b010;

        // Power-on reset with MDU requesting.
        @(posedge clk);
        #1;
        check("rst_we3",   64'(o_we3),   64'd0);
        check("rst_a3",    64'(o_a3),    64'd0);
        check("rst_wd3",   o_wd3,        64'd0);
        check("rst_gid",   64'(o_gid),   64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_busy",  64'(o_busy),  64'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        // All three continuously valid, rd 1/2/3: ALU, MDU, LSU, ALU.
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) present(k, 5'(k + 1), {32'(c), 32'(k)});
            end
            cycle();
        end
        drain();

        // Single ALU request with one-cycle latency then idle.
        present(0, 5'd5, 64'hDEAD_BEEF_0000_0001);
        cycle();
        cycle();
        cycle();

        // Pointer holds across idle cycles after an MDU grant.
        present(1, 5'd7, 64'h7777);
        cycle();
        cycle();
        cycle();
        present(0, 5'd8, 64'h8888);
        present(2, 5'd9, 64'h9999);
        cycle();
        cycle();
        cycle();

        // x0 write from LSU.
        present(2, 5'd0, 64'h1234);
        cycle();
        cycle();

        // Same rd from MDU then LSU with pointer at 1.
        present(0, 5'd3, 64'h3333);
        cycle();
        present(1, 5'd10, 64'hAA);
        present(2, 5'd10, 64'hBB);
        cycle();
        cycle();
        cycle();
        cycle();
        check("rd10_last_wins", dut_rf[10], 64'hBB);

        // Reset asserted mid-cycle while MDU is requesting.
        present(1, 5'd12, 64'hC0FFEE);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_we3",   64'(o_we3),   64'd0);
        check("mrst_a3",    64'(o_a3),    64'd0);
        check("mrst_wd3",   o_wd3,        64'd0);
        check("mrst_gid",   64'(o_gid),   64'd0);
        check("mrst_ready", 64'(o_ready), 64'd0);
        check("mrst_busy",  64'(o_busy),  64'd0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) present(k, 5'(k + 20), 64'(k + 100));
        cycle();
        drain();

        // Randomised traffic with frequent rd collisions and x0 writes.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 1) == 1)
                    present(k, 5'($urandom_range(0, 15)), {$urandom, $urandom});
            end
            cycle();
        end
        drain();
        cycle();

        for (int r = 1; r < 32; r++) begin
            check($sformatf("rf[%0d]", r), dut_rf[r], model_rf[r]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
